// File: rtl/add_sub_unit_pipelined.sv
// Pipelined add/subtract functional unit.
// The arithmetic is done once, when an op is accepted into stage 1. The
// DATA_W+1-bit result is then carried unchanged down a LATENCY-deep shift
// register. The last stage presents the result and tag to the CDB arbiter.
// The whole pipeline freezes while a presented result waits for its grant.
module add_sub_unit_pipelined #(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 3,
    parameter int LATENCY = 4,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_op,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  result_tag,
    output logic              result_carry,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    // Index 0 is stage 1; index LATENCY-1 is the output stage.
    logic              valid_reg [LATENCY];
    logic [TAG_W-1:0]  tag_reg   [LATENCY];
    logic [DATA_W-1:0] data_reg  [LATENCY];
    logic              carry_reg [LATENCY];

    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic              stall;
    logic              accept;
    logic              retire;
    logic [DATA_W:0]   calc;

    // Handshake decode. A grant that arrives with no request present is ignored.
    always_comb begin
        stall  = valid_reg[LATENCY-1] & ~cdb_grant;
        accept = issue_valid & ~stall;
        retire = valid_reg[LATENCY-1] & cdb_grant;
    end

    // Full-width add or subtract. For a subtract, bit DATA_W is the borrow.
    always_comb begin
        if (issue_op) begin
            calc = {1'b0, src1} - {1'b0, src2};
        end else begin
            calc = {1'b0, src1} + {1'b0, src2};
        end
    end

    // Stage 1 loads a new op on accept and takes a bubble otherwise.
    // Its data fields are kept unchanged while a bubble passes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg[0] <= 1'b0;
            tag_reg[0]   <= '0;
            data_reg[0]  <= '0;
            carry_reg[0] <= 1'b0;
        end else if (flush) begin
            valid_reg[0] <= 1'b0;
        end else if (!stall) begin
            valid_reg[0] <= accept;
            if (accept) begin
                tag_reg[0]   <= issue_tag;
                data_reg[0]  <= calc[DATA_W-1:0];
                carry_reg[0] <= calc[DATA_W];
            end
        end
    end

    // Stages 2..LATENCY shift together and hold together under stall.
    // Bubbles hold as well, so no gap ever closes up.
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg[gi] <= 1'b0;
                tag_reg[gi]   <= '0;
                data_reg[gi]  <= '0;
                carry_reg[gi] <= 1'b0;
            end else if (flush) begin
                valid_reg[gi] <= 1'b0;
            end else if (!stall) begin
                valid_reg[gi] <= valid_reg[gi-1];
                tag_reg[gi]   <= tag_reg[gi-1];
                data_reg[gi]  <= data_reg[gi-1];
                carry_reg[gi] <= carry_reg[gi-1];
            end
        end
    end

    // Occupancy: add one on accept, subtract one on retire, no change when both happen.
    always_comb begin
        count_next = count_reg;
        if (accept && !retire) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!accept && retire) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Occupancy register. A flush empties the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // The output stage drives the CDB request directly.
    always_comb begin
        issue_ready  = ~stall;
        cdb_req      = valid_reg[LATENCY-1];
        result       = data_reg[LATENCY-1];
        result_tag   = tag_reg[LATENCY-1];
        result_carry = carry_reg[LATENCY-1];
        count        = count_reg;
        busy         = (count_reg != '0);
    end

endmodule

// File: tb/tb_add_sub_unit_pipelined.sv
// Directed bench for add_sub_unit_pipelined.
// Instance u_dut is the default build (8-bit data, 3-bit tag, LATENCY=4).
// Instance u_fast is a 16-bit, 4-bit tag, LATENCY=1 build.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, well away from the next active edge.
module tb_add_sub_unit_pipelined;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Signals for the default instance.
    logic       flush = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic       issue_op = 1'b0;
    logic [2:0] issue_tag = '0;
    logic [7:0] src1 = '0;
    logic [7:0] src2 = '0;
    logic       cdb_req;
    logic       cdb_grant = 1'b0;
    logic [7:0] result;
    logic [2:0] result_tag;
    logic       result_carry;
    logic [2:0] count;
    logic       busy;

    // Signals for the LATENCY=1 instance.
    logic        p_flush = 1'b0;
    logic        p_issue_valid = 1'b0;
    logic        p_issue_ready;
    logic        p_issue_op = 1'b0;
    logic [3:0]  p_issue_tag = '0;
    logic [15:0] p_src1 = '0;
    logic [15:0] p_src2 = '0;
    logic        p_cdb_req;
    logic        p_cdb_grant = 1'b0;
    logic [15:0] p_result;
    logic [3:0]  p_result_tag;
    logic        p_result_carry;
    logic [0:0]  p_count;
    logic        p_busy;

    int errors = 0;
    int checks = 0;

    add_sub_unit_pipelined u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_op     (issue_op),
        .issue_tag    (issue_tag),
        .src1         (src1),
        .src2         (src2),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .result       (result),
        .result_tag   (result_tag),
        .result_carry (result_carry),
        .count        (count),
        .busy         (busy)
    );

    add_sub_unit_pipelined #(.DATA_W(16), .TAG_W(4), .LATENCY(1)) u_fast (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (p_flush),
        .issue_valid  (p_issue_valid),
        .issue_ready  (p_issue_ready),
        .issue_op     (p_issue_op),
        .issue_tag    (p_issue_tag),
        .src1         (p_src1),
        .src2         (p_src2),
        .cdb_req      (p_cdb_req),
        .cdb_grant    (p_cdb_grant),
        .result       (p_result),
        .result_tag   (p_result_tag),
        .result_carry (p_result_carry),
        .count        (p_count),
        .busy         (p_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [2:0] tag, input logic [7:0] a, input logic [7:0] b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_tag   = tag;
        src1        = a;
        src2        = b;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", cdb_req); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", issue_ready); end
        // Put two ops in flight while stalled, then pull reset mid-cycle.
        cdb_grant = 1'b0;
        issue(1'b0, 3'd6, 8'h33, 8'h44);
        tick();
        issue(1'b1, 3'd7, 8'h55, 8'h11);
        tick();
        idle();
        tick();
        tick();
        checks++; if (cdb_req !== 1'b1 || result !== 8'h77) begin errors++; $display("FAIL pre_reset_req got=%b/%h want=1/77", cdb_req, result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL async_reset_req got=%b want=0", cdb_req); end
        checks++; if (count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_count got=%0d/%b want=0/0", count, busy); end
        checks++; if (result !== 8'h00 || result_tag !== 3'd0 || result_carry !== 1'b0) begin
            errors++; $display("FAIL async_reset_data got=%h/%0d/%b want=00/0/0", result, result_tag, result_carry);
        end
        tick();
        rst_n = 1'b1;
        $display("reset: async reset with ops in flight cleared outputs");
    endtask

    task automatic test_basic_add();
        cdb_grant = 1'b1;
        issue(1'b0, 3'd5, 8'h7F, 8'h01);
        tick();
        idle();
        checks++; if (count !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL add_count got=%0d/%b want=1/1", count, busy); end
        tick();
        tick();
        checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL add_early_req got=%b want=0", cdb_req); end
        tick();
        checks++; if (cdb_req !== 1'b1 || result !== 8'h80 || result_tag !== 3'd5 || result_carry !== 1'b0) begin
            errors++; $display("FAIL add_result got=%b/%h/%0d/%b want=1/80/5/0", cdb_req, result, result_tag, result_carry);
        end
        $display("add: 7f+01 tag=%0d -> result=%h carry=%b", result_tag, result, result_carry);
        tick();
        checks++; if (count !== 3'd0 || busy !== 1'b0 || cdb_req !== 1'b0) begin
            errors++; $display("FAIL add_drain got=%0d/%b/%b want=0/0/0", count, busy, cdb_req);
        end
    endtask

    task automatic test_carry_borrow();
        logic [2:0] exp_tag [3] = '{3'd1, 3'd2, 3'd3};
        logic [7:0] exp_res [3] = '{8'h01, 8'hF0, 8'h10};
        logic       exp_cy  [3] = '{1'b1, 1'b1, 1'b0};
        cdb_grant = 1'b1;
        issue(1'b0, 3'd1, 8'hFF, 8'h02);
        tick();
        issue(1'b1, 3'd2, 8'h10, 8'h20);
        tick();
        issue(1'b1, 3'd3, 8'h20, 8'h10);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cdb_req !== 1'b1 || result !== exp_res[i] || result_tag !== exp_tag[i] || result_carry !== exp_cy[i]) begin
                errors++;
                $display("FAIL carry_op%0d got=%b/%h/%0d/%b want=1/%h/%0d/%b", i, cdb_req, result, result_tag,
                         result_carry, exp_res[i], exp_tag[i], exp_cy[i]);
            end
            $display("carry: tag=%0d result=%h carry=%b", result_tag, result, result_carry);
        end
        tick();
        checks++; if (cdb_req !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL carry_drain got=%b/%0d want=0/0", cdb_req, count); end
    endtask

    task automatic test_back_pressure();
        logic [2:0] t;
        cdb_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t = 3'(k);
            issue(1'b0, t, {t, 4'h0} >> 0, {5'd0, t});
            tick();
        end
        // Tag 4 is presented but must be refused while tag 0 waits.
        issue(1'b0, 3'd4, 8'h40, 8'h04);
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b want=0", issue_ready); end
        checks++; if (count !== 3'd4 || cdb_req !== 1'b1 || result_tag !== 3'd0 || result !== 8'h00) begin
            errors++; $display("FAIL bp_full got=%0d/%b/%0d/%h want=4/1/0/00", count, cdb_req, result_tag, result);
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (cdb_req !== 1'b1 || result_tag !== 3'd0 || result !== 8'h00 || count !== 3'd4 || issue_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%0d/%h/%0d want=1/0/00/4", s, cdb_req, result_tag, result, count);
            end
        end
        cdb_grant = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_grant got=%b want=1", issue_ready); end
        tick();
        issue(1'b0, 3'd5, 8'h50, 8'h05);
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (cdb_req !== 1'b1 || result_tag !== 3'(k) || result !== 8'(8'h11 * k)) begin
                errors++; $display("FAIL bp_retire%0d got=%b/%0d/%h want=1/%0d/%h", k, cdb_req, result_tag, result, k, 8'(8'h11 * k));
            end
            $display("retire: tag=%0d result=%h count=%0d", result_tag, result, count);
            tick();
            idle();
        end
        checks++; if (cdb_req !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL bp_drain got=%b/%0d want=0/0", cdb_req, count); end
    endtask

    task automatic test_simultaneous();
        cdb_grant = 1'b0;
        issue(1'b1, 3'd1, 8'h09, 8'h03);
        tick();
        issue(1'b0, 3'd2, 8'h01, 8'h01);
        tick();
        issue(1'b0, 3'd3, 8'h02, 8'h02);
        tick();
        issue(1'b0, 3'd4, 8'h03, 8'h03);
        tick();
        issue(1'b0, 3'd7, 8'hA0, 8'h0A);
        cdb_grant = 1'b1;
        tick();
        idle();
        cdb_grant = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_count got=%0d want=4", count); end
        checks++; if (result_tag !== 3'd2 || result !== 8'h02) begin errors++; $display("FAIL simul_next got=%0d/%h want=2/02", result_tag, result); end
        cdb_grant = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (result_tag !== 3'd7 || result !== 8'hAA || cdb_req !== 1'b1) begin
            errors++; $display("FAIL simul_new got=%0d/%h/%b want=7/aa/1", result_tag, result, cdb_req);
        end
        $display("simul: new op tag=%0d result=%h", result_tag, result);
        tick();
    endtask

    task automatic test_flush();
        cdb_grant = 1'b1;
        issue(1'b0, 3'd1, 8'h01, 8'h01);
        tick();
        issue(1'b0, 3'd2, 8'h02, 8'h02);
        tick();
        issue(1'b0, 3'd3, 8'h03, 8'h03);
        tick();
        issue(1'b0, 3'd6, 8'h06, 8'h06);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++; if (count !== 3'd0 || busy !== 1'b0 || cdb_req !== 1'b0) begin
            errors++; $display("FAIL flush_clear got=%0d/%b/%b want=0/0/0", count, busy, cdb_req);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d got=%b want=0", i, cdb_req); end
        end
        $display("flush: pipeline squashed, no op emerged");
    endtask

    task automatic test_latency1();
        p_cdb_grant   = 1'b1;
        p_issue_valid = 1'b1;
        p_issue_op    = 1'b0;
        p_issue_tag   = 4'd9;
        p_src1        = 16'hFFFF;
        p_src2        = 16'h0001;
        checks++; if (p_cdb_req !== 1'b0) begin errors++; $display("FAIL lat1_idle got=%b want=0", p_cdb_req); end
        tick();
        p_issue_op  = 1'b1;
        p_issue_tag = 4'd3;
        p_src1      = 16'h0001;
        p_src2      = 16'h0002;
        checks++; if (p_cdb_req !== 1'b1 || p_result !== 16'h0000 || p_result_carry !== 1'b1 || p_result_tag !== 4'd9) begin
            errors++; $display("FAIL lat1_add got=%b/%h/%b/%0d want=1/0000/1/9", p_cdb_req, p_result, p_result_carry, p_result_tag);
        end
        $display("lat1: tag=%0d result=%h carry=%b", p_result_tag, p_result, p_result_carry);
        tick();
        p_issue_valid = 1'b0;
        checks++; if (p_cdb_req !== 1'b1 || p_result !== 16'hFFFF || p_result_carry !== 1'b1 || p_result_tag !== 4'd3 || p_count !== 1'b1) begin
            errors++; $display("FAIL lat1_sub got=%b/%h/%b/%0d want=1/ffff/1/3", p_cdb_req, p_result, p_result_carry, p_result_tag);
        end
        $display("lat1: tag=%0d result=%h carry=%b", p_result_tag, p_result, p_result_carry);
        tick();
        checks++; if (p_cdb_req !== 1'b0 || p_count !== 1'b0 || p_busy !== 1'b0) begin
            errors++; $display("FAIL lat1_drain got=%b/%0d/%b want=0/0/0", p_cdb_req, p_count, p_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_borrow();
        test_back_pressure();
        test_simultaneous();
        test_flush();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
